// File: rtl/clock_route_path_switch_ctrl.sv
// Break-before-make switch controller for a bank of gated clock route paths.
// All enables drop for a fixed dwell before the new path opens, then settle before done.
module clock_route_path_switch_ctrl #(
  parameter int NUM_PATHS  = 4,
  parameter int OFF_CYCLES = 4,
  parameter int ON_CYCLES  = 2,
  localparam int SEL_W     = (NUM_PATHS > 2) ? $clog2(NUM_PATHS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sel_req_valid,
  output logic                 sel_req_ready,
  input  logic [SEL_W-1:0]     sel_req_path,
  input  logic                 sel_req_off,
  input  logic                 async_test_en,
  output logic [NUM_PATHS-1:0] control_path_enable,
  output logic [SEL_W-1:0]     cur_path,
  output logic                 cur_path_on,
  output logic                 switch_busy,
  output logic                 switch_done,
  output logic                 sel_req_err
);

  // state    | meaning
  // S_IDLE   | waiting for a request; ready when not in test mode
  // S_GATEOFF| every enable low, OFF_CYCLES dwell
  // S_GATEON | target enable high, ON_CYCLES settle
  // S_DONE   | one-cycle completion pulse
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GATEOFF = 2'd1,
    S_GATEON  = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam int CNT_MAX = (OFF_CYCLES > ON_CYCLES) ? OFF_CYCLES : ON_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [SEL_W:0]   NUM_EXT  = (SEL_W + 1)'(NUM_PATHS);
  localparam logic [NUM_PATHS-1:0] ONE_HOT_0 = NUM_PATHS'(1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_PATHS-1:0] en_q, en_d;
  logic [SEL_W-1:0]     cur_path_q, cur_path_d;
  logic                 cur_on_q, cur_on_d;
  logic [SEL_W-1:0]     tgt_path_q, tgt_path_d;
  logic                 tgt_off_q, tgt_off_d;
  logic                 err_q, err_d;

  logic accept;
  logic path_invalid;
  logic path_already_on;

  assign sel_req_ready   = (state_q == S_IDLE) && !async_test_en && !rst;
  assign accept          = sel_req_valid && sel_req_ready;
  assign path_invalid    = ({1'b0, sel_req_path} >= NUM_EXT);
  assign path_already_on = cur_on_q && (sel_req_path == cur_path_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    en_d       = en_q;
    cur_path_d = cur_path_q;
    cur_on_d   = cur_on_q;
    tgt_path_d = tgt_path_q;
    tgt_off_d  = tgt_off_q;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!sel_req_off && path_invalid) begin
            err_d = 1'b1;
          end else if (!sel_req_off && path_already_on) begin
            state_d = S_DONE;
          end else begin
            // request fields are captured here only; later input changes are ignored
            tgt_path_d = sel_req_path;
            tgt_off_d  = sel_req_off;
            en_d       = '0;
            cur_on_d   = 1'b0;
            cnt_d      = OFF_LOAD;
            state_d    = S_GATEOFF;
          end
        end
      end
      S_GATEOFF: begin
        if (cnt_q == '0) begin
          if (tgt_off_q) begin
            state_d = S_DONE;
          end else begin
            en_d       = ONE_HOT_0 << tgt_path_q;
            cur_path_d = tgt_path_q;
            cur_on_d   = 1'b1;
            cnt_d      = ON_LOAD;
            state_d    = S_GATEON;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GATEON: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      en_q       <= '0;
      cur_path_q <= '0;
      cur_on_q   <= 1'b0;
      tgt_path_q <= '0;
      tgt_off_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      cur_path_q <= cur_path_d;
      cur_on_q   <= cur_on_d;
      tgt_path_q <= tgt_path_d;
      tgt_off_q  <= tgt_off_d;
      err_q      <= err_d;
    end
  end

  assign control_path_enable = en_q;
  assign cur_path            = cur_path_q;
  assign cur_path_on         = cur_on_q;
  assign switch_busy         = (state_q != S_IDLE);
  assign switch_done         = (state_q == S_DONE);
  assign sel_req_err         = err_q;

endmodule

// File: tb/tb_clock_route_path_switch_ctrl.sv
// Scoreboard bench: directed requests push expected completions; a negedge monitor checks them.
module tb_clock_route_path_switch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, test_en;
  logic v0, o0, r0, con0, busy0, done0, err0;
  logic [1:0] p0, cp0;
  logic [3:0] en0;
  logic v1, o1, r1, con1, busy1, done1, err1;
  logic [2:0] p1, cp1;
  logic [4:0] en1;

  clock_route_path_switch_ctrl u_dut (
    .clk(clk), .rst(rst), .sel_req_valid(v0), .sel_req_ready(r0),
    .sel_req_path(p0), .sel_req_off(o0), .async_test_en(test_en),
    .control_path_enable(en0), .cur_path(cp0), .cur_path_on(con0),
    .switch_busy(busy0), .switch_done(done0), .sel_req_err(err0)
  );

  clock_route_path_switch_ctrl #(.NUM_PATHS(5)) u_dut5 (
    .clk(clk), .rst(rst), .sel_req_valid(v1), .sel_req_ready(r1),
    .sel_req_path(p1), .sel_req_off(o1), .async_test_en(test_en),
    .control_path_enable(en1), .cur_path(cp1), .cur_path_on(con1),
    .switch_busy(busy1), .switch_done(done1), .sel_req_err(err1)
  );

  typedef struct {
    int          id;
    bit          is_err;
    int          t;
    int          t_done;
    int          zl;
    logic [15:0] en;
    int          cp;
    bit          con;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  logic rst_s = 1'b1, rst_s_prev = 1'b1;
  int   n_chk = 0, n_fail = 0;
  logic [15:0] prev_en [2] = '{16'h0, 16'h0};
  int   idle_chk [2] = '{-1, -1};

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    rst_s_prev <= rst_s;
    rst_s      <= rst;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic mon_step(input int id, input logic [15:0] en, input int cp, input logic con,
                          input logic busy, input logic done, input logic err, input logic ready);
    string pre;
    bit    front;
    exp_t  e;
    pre = (id == 0) ? "d4_" : "d5_";
    if (rst_s) begin
      chk({pre, "rst_en"},   32'(en),   32'(0));
      chk({pre, "rst_cp"},   32'(cp),   32'(0));
      chk({pre, "rst_on"},   32'(con),  32'(0));
      chk({pre, "rst_busy"}, 32'(busy), 32'(0));
      chk({pre, "rst_done"}, 32'(done), 32'(0));
      chk({pre, "rst_err"},  32'(err),  32'(0));
    end
    if (rst) chk({pre, "ready_in_rst"}, 32'(ready), 32'(0));
    if (rst_s_prev && !rst_s) chk({pre, "ready_after_rst"}, 32'(ready), 32'(!test_en));
    if (test_en) chk({pre, "ready_test"}, 32'(ready), 32'(0));
    chk({pre, "onehot0"}, 32'($countones(en) <= 1), 32'(1));
    if (prev_en[id] != 16'h0 && en != 16'h0)
      chk({pre, "no_adjacent"}, 32'(en), 32'(prev_en[id]));
    if (test_en && !busy && !rst_s) chk({pre, "test_hold"}, 32'(en), 32'(prev_en[id]));
    if (!rst_s) begin
      front = (q.size() > 0) && (q[0].id == id);
      if (front && !q[0].is_err && cyc > q[0].t && cyc <= q[0].t_done) begin
        chk({pre, "seq_busy"}, 32'(busy), 32'(1));
        if (cyc <= q[0].t + q[0].zl) begin
          chk({pre, "gate_off_en"}, 32'(en), 32'(0));
          chk({pre, "gate_off_on"}, 32'(con), 32'(0));
        end else begin
          chk({pre, "path_en"}, 32'(en), 32'(q[0].en));
        end
      end
      if (done || err) begin
        if (!front) begin
          chk({pre, "unexpected_pulse"}, 32'({done, err}), 32'(0));
        end else begin
          e = q.pop_front();
          chk({pre, "pulse_kind"},  32'({done, err}), e.is_err ? 32'(1) : 32'(2));
          chk({pre, "pulse_cycle"}, 32'(cyc), 32'(e.t_done));
          chk({pre, "pulse_en"},    32'(en),  32'(e.en));
          chk({pre, "pulse_cp"},    32'(cp),  32'(e.cp));
          chk({pre, "pulse_on"},    32'(con), 32'(e.con));
          if (e.is_err) begin
            chk({pre, "err_busy"},  32'(busy),  32'(0));
            chk({pre, "err_ready"}, 32'(ready), 32'(1));
          end
          idle_chk[id] = cyc + 1;
        end
      end else if (front && cyc >= q[0].t_done) begin
        chk({pre, "missing_pulse"}, 32'(0), 32'(1));
        e = q.pop_front();
      end
      if (cyc == idle_chk[id]) begin
        chk({pre, "idle_busy"}, 32'(busy), 32'(0));
        if (!test_en) chk({pre, "idle_ready"}, 32'(ready), 32'(1));
      end
    end
    prev_en[id] = en;
  endtask

  always @(negedge clk) begin
    mon_step(0, 16'(en0), 32'(cp0), con0, busy0, done0, err0, r0);
    mon_step(1, 16'(en1), 32'(cp1), con1, busy1, done1, err1, r1);
  end

  task automatic do_req(input int id, input int path, input bit off, input bit is_err,
                        input int zl, input int dd, input logic [15:0] ef,
                        input int ecp, input bit econ);
    int   n;
    exp_t e;
    n = 0;
    @(posedge clk); #1;
    while (!((id == 0) ? r0 : r1) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      chk("ready_timeout", 32'(0), 32'(1));
      return;
    end
    e = '{id, is_err, cyc, cyc + dd, zl, ef, ecp, econ};
    q.push_back(e);
    if (id == 0) begin
      v0 = 1'b1; p0 = path[1:0]; o0 = off;
    end else begin
      v1 = 1'b1; p1 = path[2:0]; o1 = off;
    end
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
    p0 = ~p0; p1 = ~p1; o0 = ~o0; o1 = ~o1;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("done_timeout", 32'(q.size()), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d required=<10000", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; test_en = 1'b0;
    v0 = 1'b0; p0 = '0; o0 = 1'b0;
    v1 = 1'b0; p1 = '0; o1 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // default instance: id, path, off, err, zero_len, done_delay, enables, cur_path, cur_on
    do_req(0, 2, 0, 0, 4, 7, 16'h0004, 2, 1);
    do_req(0, 1, 0, 0, 4, 7, 16'h0002, 1, 1);
    do_req(0, 1, 0, 0, 0, 1, 16'h0002, 1, 1);
    do_req(0, 3, 0, 0, 4, 7, 16'h0008, 3, 1);
    do_req(0, 0, 1, 0, 4, 5, 16'h0000, 3, 0);
    do_req(0, 2, 1, 0, 4, 5, 16'h0000, 3, 0);
    do_req(0, 3, 0, 0, 4, 7, 16'h0008, 3, 1);

    // test mode raised mid-sequence: completes, then requests are ignored
    fork
      do_req(0, 0, 0, 0, 4, 7, 16'h0001, 0, 1);
      begin
        repeat (3) @(posedge clk);
        #1 test_en = 1'b1;
      end
    join
    v0 = 1'b1; p0 = 2'd2; o0 = 1'b0;
    repeat (5) @(posedge clk);
    #1 v0 = 1'b0; test_en = 1'b0;

    // reset lands at T+3 of a switch to path 2: no completion expected
    @(posedge clk); #1;
    v0 = 1'b1; p0 = 2'd2; o0 = 1'b0;
    @(posedge clk); #1 v0 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;

    do_req(0, 2, 0, 0, 4, 7, 16'h0004, 2, 1);

    // five-path instance: out-of-range indices are rejected
    do_req(1, 5, 0, 1, 0, 1, 16'h0000, 0, 0);
    do_req(1, 4, 0, 0, 4, 7, 16'h0010, 4, 1);
    do_req(1, 7, 0, 1, 0, 1, 16'h0010, 4, 1);
    do_req(1, 0, 1, 0, 4, 5, 16'h0000, 4, 0);

    repeat (3) @(posedge clk);
    #1 chk("queue_drained", 32'(q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
